// File: rtl/pe_row_scheduler_pkg.sv
// Shared constants and FSM state type for the PE row scheduler.
package pe_row_scheduler_pkg;

  localparam int unsigned MAX_SEQ_LEN = 64;
  localparam int unsigned IDX_W       = $clog2(MAX_SEQ_LEN);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StFinish
  } pe_sched_state_t;

endpackage

// File: rtl/pe_row_scheduler_beat_joiner.sv
// Joins the independent Q, K and V handshakes of one beat. Each channel is
// offered once per beat; the beat completes when the last outstanding channel
// fires, which also rearms all three channels for the next beat.
module beat_joiner (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic q_src_vld,
  input  logic kv_src_vld,
  input  logic q_rdy,
  input  logic k_rdy,
  input  logic v_rdy,
  output logic q_vld,
  output logic k_vld,
  output logic v_vld,
  output logic beat_done
);

  logic q_sent_q, k_sent_q, v_sent_q;
  logic q_fire, k_fire, v_fire;

  // Offer each channel until it fires; valids never look at the ready inputs.
  always_comb begin
    q_vld     = en & q_src_vld & ~q_sent_q;
    k_vld     = en & kv_src_vld & ~k_sent_q;
    v_vld     = en & kv_src_vld & ~v_sent_q;
    q_fire    = q_vld & q_rdy;
    k_fire    = k_vld & k_rdy;
    v_fire    = v_vld & v_rdy;
    beat_done = en & (q_sent_q | q_fire) & (k_sent_q | k_fire) & (v_sent_q | v_fire);
  end

  // Sent flags: set on fire, cleared on beat completion or an explicit clear.
  always_ff @(posedge clk) begin
    if (!rst || clear || beat_done) begin
      q_sent_q <= 1'b0;
      k_sent_q <= 1'b0;
      v_sent_q <= 1'b0;
    end else begin
      q_sent_q <= q_sent_q | q_fire;
      k_sent_q <= k_sent_q | k_fire;
      v_sent_q <= v_sent_q | v_fire;
    end
  end

endmodule

// File: rtl/pe_row_scheduler.sv
// Sequences one PE backend through the query rows of an attention head:
// clear the PE, stream every key beat for the row, then forward only the
// final normalized PE output to the writer.
module pe_row_scheduler
  import pe_row_scheduler_pkg::*;
#(
  parameter int unsigned MAX_SEQ_LEN = pe_row_scheduler_pkg::MAX_SEQ_LEN,
  parameter int unsigned IDX_W       = $clog2(MAX_SEQ_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W:0]   seq_len_q,
  input  logic [IDX_W:0]   seq_len_k,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] q_idx,
  output logic [IDX_W-1:0] k_idx,
  input  logic             q_src_vld,
  input  logic             kv_src_vld,
  output logic             q_pe_vld,
  output logic             k_pe_vld,
  output logic             v_pe_vld,
  input  logic             q_pe_rdy,
  input  logic             k_pe_rdy,
  input  logic             v_pe_rdy,
  output logic             pe_clear,
  input  logic             pe_out_vld,
  output logic             pe_ctrl_rdy,
  output logic             o_wr_vld,
  output logic [IDX_W-1:0] o_wr_idx,
  input  logic             o_wr_rdy
);

  localparam int unsigned CntW = IDX_W + 1;

  pe_sched_state_t state_q, state_d;
  logic [CntW-1:0] rows_q, rows_d;
  logic [CntW-1:0] keys_q, keys_d;
  logic [CntW-1:0] row_q, row_d;
  logic [CntW-1:0] k_cnt_q, k_cnt_d;
  logic [CntW-1:0] out_cnt_q, out_cnt_d;

  logic stream_en;
  logic last_out;
  logic out_fire;
  logic final_fire;
  logic beat_done;

  beat_joiner u_beat_joiner (
    .clk        (clk),
    .rst        (rst),
    .en         (stream_en),
    .clear      (pe_clear),
    .q_src_vld  (q_src_vld),
    .kv_src_vld (kv_src_vld),
    .q_rdy      (q_pe_rdy),
    .k_rdy      (k_pe_rdy),
    .v_rdy      (v_pe_rdy),
    .q_vld      (q_pe_vld),
    .k_vld      (k_pe_vld),
    .v_vld      (v_pe_vld),
    .beat_done  (beat_done)
  );

  assign q_idx    = row_q[IDX_W-1:0];
  assign k_idx    = k_cnt_q[IDX_W-1:0];
  assign o_wr_idx = row_q[IDX_W-1:0];

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    rows_d      = rows_q;
    keys_d      = keys_q;
    row_d       = row_q;
    k_cnt_d     = k_cnt_q;
    out_cnt_d   = out_cnt_q;
    busy        = 1'b0;
    done        = 1'b0;
    pe_clear    = 1'b0;
    pe_ctrl_rdy = 1'b0;
    o_wr_vld    = 1'b0;
    stream_en   = 1'b0;
    out_fire    = 1'b0;
    final_fire  = 1'b0;
    last_out    = (out_cnt_q == keys_q - CntW'(1));

    // Intermediate PE outputs are swallowed; the last one per row waits on the writer.
    if (state_q == StStream || state_q == StDrain) begin
      if (last_out) begin
        pe_ctrl_rdy = o_wr_rdy;
        o_wr_vld    = pe_out_vld;
      end else begin
        pe_ctrl_rdy = 1'b1;
      end
      out_fire   = pe_out_vld & pe_ctrl_rdy;
      final_fire = out_fire & last_out;
      if (out_fire && !last_out) begin
        out_cnt_d = out_cnt_q + CntW'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (seq_len_q != '0 && seq_len_k != '0) begin
            rows_d  = seq_len_q;
            keys_d  = seq_len_k;
            row_d   = '0;
            state_d = StClear;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StClear: begin
        busy      = 1'b1;
        pe_clear  = 1'b1;
        k_cnt_d   = '0;
        out_cnt_d = '0;
        state_d   = StStream;
      end
      StStream: begin
        busy      = 1'b1;
        stream_en = 1'b1;
        if (beat_done) begin
          k_cnt_d = k_cnt_q + CntW'(1);
          if (k_cnt_q + CntW'(1) == keys_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (final_fire) begin
          if (row_q + CntW'(1) == rows_q) begin
            state_d = StFinish;
          end else begin
            row_d   = row_q + CntW'(1);
            state_d = StClear;
          end
        end
      end
      StFinish: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      rows_q    <= '0;
      keys_q    <= '0;
      row_q     <= '0;
      k_cnt_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      keys_q    <= keys_d;
      row_q     <= row_d;
      k_cnt_q   <= k_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // The final output of a row can only follow the row's last beat.
  a_no_final_in_stream : assert property (
    @(posedge clk) disable iff (!rst) !(state_q == StStream && final_fire)
  );

endmodule

// File: tb/tb_pe_row_scheduler.sv
// Directed bench for pe_row_scheduler with a small behavioural PE that emits
// one output per completed beat of the current row.
module tb_pe_row_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] seq_len_q, seq_len_k;
  logic       busy, done;
  logic [5:0] q_idx, k_idx, o_wr_idx;
  logic       q_src_vld, kv_src_vld;
  logic       q_pe_vld, k_pe_vld, v_pe_vld;
  logic       q_pe_rdy, k_pe_rdy, v_pe_rdy;
  logic       pe_clear, pe_out_vld, pe_ctrl_rdy;
  logic       o_wr_vld, o_wr_rdy;

  int n_checks = 0;
  int n_err    = 0;

  pe_row_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .seq_len_q   (seq_len_q),
    .seq_len_k   (seq_len_k),
    .busy        (busy),
    .done        (done),
    .q_idx       (q_idx),
    .k_idx       (k_idx),
    .q_src_vld   (q_src_vld),
    .kv_src_vld  (kv_src_vld),
    .q_pe_vld    (q_pe_vld),
    .k_pe_vld    (k_pe_vld),
    .v_pe_vld    (v_pe_vld),
    .q_pe_rdy    (q_pe_rdy),
    .k_pe_rdy    (k_pe_rdy),
    .v_pe_rdy    (v_pe_rdy),
    .pe_clear    (pe_clear),
    .pe_out_vld  (pe_out_vld),
    .pe_ctrl_rdy (pe_ctrl_rdy),
    .o_wr_vld    (o_wr_vld),
    .o_wr_idx    (o_wr_idx),
    .o_wr_rdy    (o_wr_rdy)
  );

  always #5 clk = ~clk;

  // Handshakes that will occur at the next rising edge, sampled mid-cycle.
  logic       c_q, c_k, c_v, c_o, c_w, c_clr, c_dn, c_disc;
  logic [5:0] c_kidx, c_widx;
  always @(negedge clk) begin
    c_q    <= q_pe_vld & q_pe_rdy;
    c_k    <= k_pe_vld & k_pe_rdy;
    c_v    <= v_pe_vld & v_pe_rdy;
    c_o    <= pe_out_vld & pe_ctrl_rdy;
    c_w    <= o_wr_vld & o_wr_rdy;
    c_disc <= pe_out_vld & pe_ctrl_rdy & ~o_wr_vld;
    c_clr  <= pe_clear;
    c_dn   <= done;
    c_kidx <= k_idx;
    c_widx <= o_wr_idx;
  end

  int n_q = 0, n_k = 0, n_v = 0, n_wr = 0, n_disc = 0, n_clr = 0, n_done = 0;
  int cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  int rq = 0, rk = 0, rv = 0, ro = 0;
  logic [5:0] klog [0:255];
  logic [5:0] wlog [0:255];

  // Event tallies and the PE model; nothing is counted on a reset edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (c_q) n_q <= n_q + 1;
      if (c_v) n_v <= n_v + 1;
      if (c_k) begin
        klog[n_k[7:0]] <= c_kidx;
        n_k <= n_k + 1;
      end
      if (c_w) begin
        wlog[n_wr[7:0]] <= c_widx;
        n_wr <= n_wr + 1;
        last_wr_cyc <= cyc;
      end
      if (c_disc) n_disc <= n_disc + 1;
      if (c_clr) n_clr <= n_clr + 1;
      if (c_dn) begin
        n_done <= n_done + 1;
        done_cyc <= cyc;
      end
      if (c_clr) begin
        rq <= 0; rk <= 0; rv <= 0; ro <= 0;
      end else begin
        if (c_q) rq <= rq + 1;
        if (c_k) rk <= rk + 1;
        if (c_v) rv <= rv + 1;
        if (c_o) ro <= ro + 1;
      end
    end
  end

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  assign pe_out_vld = (min3(rq, rk, rv) > ro);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic start_head(input logic [6:0] lq, input logic [6:0] lk);
    drv_edge();
    seq_len_q = lq;
    seq_len_k = lk;
    start     = 1'b1;
    drv_edge();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int i;
    d0 = n_done;
    i  = 0;
    while (n_done == d0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    check(tag, n_done - d0, 1);
  endtask

  int q0, k0, v0, w0, x0, c0, d0, cnt;
  logic seen;

  initial begin
    rst = 1'b0; start = 1'b0; seq_len_q = '0; seq_len_k = '0;
    q_src_vld = 1'b1; kv_src_vld = 1'b1;
    q_pe_rdy = 1'b1; k_pe_rdy = 1'b1; v_pe_rdy = 1'b1; o_wr_rdy = 1'b1;
    repeat (3) drv_edge();
    rst = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q_idx", q_idx, 0);
    check("rst_k_idx", k_idx, 0);
    check("rst_clear", pe_clear, 0);
    check("rst_owr_vld", o_wr_vld, 0);
    check("rst_ctrl_rdy", pe_ctrl_rdy, 0);
    check("rst_q_vld", q_pe_vld, 0);

    // Two rows of three keys, everything ready.
    q0 = n_q; k0 = n_k; v0 = n_v; w0 = n_wr; x0 = n_disc; c0 = n_clr;
    start_head(7'd2, 7'd3);
    @(negedge clk);
    check("t1_clear_lat", pe_clear, 1);
    check("t1_busy", busy, 1);
    wait_done("t1_done", 100);
    check("t1_clears", n_clr - c0, 2);
    check("t1_q_fires", n_q - q0, 6);
    check("t1_k_fires", n_k - k0, 6);
    check("t1_v_fires", n_v - v0, 6);
    check("t1_writes", n_wr - w0, 2);
    check("t1_discards", n_disc - x0, 4);
    check("t1_widx0", wlog[w0], 0);
    check("t1_widx1", wlog[w0 + 1], 1);
    for (int i = 0; i < 6; i++) check("t1_kidx", klog[k0 + i], i % 3);
    check("t1_done_after_wr", done_cyc > last_wr_cyc, 1);

    // Skewed readiness within one beat.
    drv_edge();
    q_pe_rdy = 1'b0; k_pe_rdy = 1'b0; v_pe_rdy = 1'b0;
    q0 = n_q; k0 = n_k; v0 = n_v; w0 = n_wr;
    start_head(7'd1, 7'd2);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = q_pe_vld;
    end
    check("t2_stream", seen, 1);
    drv_edge(); q_pe_rdy = 1'b1;
    @(negedge clk); check("t2_q_vld_n", q_pe_vld, 1);
    drv_edge(); q_pe_rdy = 1'b0;
    @(negedge clk); check("t2_q_drop", q_pe_vld, 0);
    check("t2_k_hold", k_pe_vld, 1);
    drv_edge(); k_pe_rdy = 1'b1;
    @(negedge clk); check("t2_kidx_n2", k_idx, 0);
    drv_edge(); k_pe_rdy = 1'b0;
    @(negedge clk); check("t2_k_drop", k_pe_vld, 0);
    check("t2_v_hold", v_pe_vld, 1);
    check("t2_q_stay", q_pe_vld, 0);
    drv_edge(); v_pe_rdy = 1'b1;
    @(negedge clk); check("t2_kidx_n4", k_idx, 0);
    drv_edge(); q_pe_rdy = 1'b1; k_pe_rdy = 1'b1;
    @(negedge clk); check("t2_kidx_adv", k_idx, 1);
    check("t2_q_rearm", q_pe_vld, 1);
    wait_done("t2_done", 50);
    check("t2_q_fires", n_q - q0, 2);
    check("t2_k_fires", n_k - k0, 2);
    check("t2_v_fires", n_v - v0, 2);
    check("t2_writes", n_wr - w0, 1);

    // Single row, single key, writer stalls.
    drv_edge(); o_wr_rdy = 1'b0;
    w0 = n_wr;
    start_head(7'd1, 7'd1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = pe_out_vld;
    end
    check("t3_out_vld", seen, 1);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (!pe_ctrl_rdy && o_wr_vld) cnt++;
      @(negedge clk);
    end
    check("t3_stall_cycles", cnt, 5);
    check("t3_no_wr_yet", n_wr - w0, 0);
    drv_edge(); o_wr_rdy = 1'b1;
    wait_done("t3_done", 20);
    check("t3_writes", n_wr - w0, 1);
    check("t3_widx", wlog[w0], 0);

    // Zero key length: finish immediately with no PE activity.
    q0 = n_q; c0 = n_clr; d0 = n_done;
    start_head(7'd3, 7'd0);
    @(negedge clk);
    check("t4_done_t1", done, 1);
    check("t4_clear_t1", pe_clear, 0);
    check("t4_busy_t1", busy, 0);
    @(negedge clk);
    check("t4_done_t2", done, 0);
    repeat (3) @(negedge clk);
    check("t4_clears", n_clr - c0, 0);
    check("t4_q_fires", n_q - q0, 0);
    check("t4_done_cnt", n_done - d0, 1);

    // Reset during row 1, beat 2.
    w0 = n_wr;
    start_head(7'd2, 7'd3);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = q_pe_vld && q_idx == 6'd1 && k_idx == 6'd2;
    end
    check("t5_reach", seen, 1);
    #1 rst = 1'b0;
    d0 = n_done;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_q_vld", q_pe_vld, 0);
    check("t5_q_idx", q_idx, 0);
    check("t5_k_idx", k_idx, 0);
    check("t5_done", done, 0);
    check("t5_owr_vld", o_wr_vld, 0);
    drv_edge(); rst = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_no_done", n_done - d0, 0);
    check("t5_row0_wr", n_wr - w0, 1);
    w0 = n_wr; k0 = n_k;
    start_head(7'd1, 7'd2);
    wait_done("t5_restart_done", 50);
    check("t5_restart_wr", n_wr - w0, 1);
    check("t5_restart_widx", wlog[w0], 0);
    check("t5_restart_k0", klog[k0], 0);

    // Maximum key length.
    k0 = n_k; w0 = n_wr; x0 = n_disc;
    start_head(7'd1, 7'd64);
    wait_done("t6_done", 400);
    check("t6_k_fires", n_k - k0, 64);
    check("t6_kidx_first", klog[k0], 0);
    check("t6_kidx_last", klog[k0 + 63], 63);
    check("t6_writes", n_wr - w0, 1);
    check("t6_discards", n_disc - x0, 63);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
